// File: rtl/gs_mix_pkg.sv
// gs_mix_pkg: shared types and widths for the GS DAC mixer.
package gs_mix_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MUL,
        COMMIT
    } state_t;

    localparam int SMP_W     = 8;
    localparam int VOL_W     = 6;
    localparam int PROD_W    = 14;
    localparam int MIX_W     = 15;
    localparam int SD_W      = 16;
    localparam int MUL_STEPS = 6;

endpackage

// File: rtl/sd_modulator_1st.sv
// sd_modulator_1st: first-order sigma-delta modulator; the carry out of a
// 15-bit residue accumulator is the output bit, so density = mix/32768.
module sd_modulator_1st
    import gs_mix_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [MIX_W-1:0] mix,
    output logic             sd
);

    logic [MIX_W-1:0] residue;
    logic [SD_W-1:0]  sum;

    // Add the mix value to the residue; the carry is the next output bit
    always_comb begin
        sum = {1'b0, residue} + {1'b0, mix};
    end

    // Keep the residue and register the carry as the bitstream
    always_ff @(posedge clk) begin
        if (rst) begin
            residue <= '0;
            sd      <= 1'b0;
        end else begin
            residue <= sum[MIX_W-1:0];
            sd      <= sum[SD_W-1];
        end
    end

endmodule

// File: rtl/gs_dac_mixer.sv
// gs_dac_mixer: per frame, snapshots the four GS channel samples and volumes,
// scales each with a 6-step shift-add multiplier, mixes ch0+ch1 to left and
// ch2+ch3 to right (or all four halved in MONO), and drives sigma-delta pins.
module gs_dac_mixer
    import gs_mix_pkg::*;
#(
    parameter int SAMPLE_DIV = 32,
    parameter bit MONO       = 1'b0
) (
    input  logic             clk32,
    input  logic             rst,
    input  logic             en,
    input  logic [SMP_W-1:0] dac0,
    input  logic [SMP_W-1:0] dac1,
    input  logic [SMP_W-1:0] dac2,
    input  logic [SMP_W-1:0] dac3,
    input  logic [VOL_W-1:0] vol0,
    input  logic [VOL_W-1:0] vol1,
    input  logic [VOL_W-1:0] vol2,
    input  logic [VOL_W-1:0] vol3,
    output logic [MIX_W-1:0] mix_left,
    output logic [MIX_W-1:0] mix_right,
    output logic             frame_done,
    output logic             busy,
    output logic             sd_left,
    output logic             sd_right
);

    localparam int               DIV_W     = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [2:0]       STEP_LAST = 3'(MUL_STEPS - 1);

    state_t                state;
    state_t                next_state;
    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;
    logic [3:0][SMP_W-1:0] dac_snap;
    logic [3:0][VOL_W-1:0] vol_snap;
    logic [1:0]            ch_idx;
    logic [2:0]            bit_idx;
    logic [SMP_W-1:0]      cur_dac;
    logic [VOL_W-1:0]      cur_vol;
    logic [PROD_W-1:0]     addend;
    logic [PROD_W-1:0]     prod;
    logic [PROD_W-1:0]     prod_next;
    logic [MIX_W-1:0]      acc_left;
    logic [MIX_W-1:0]      acc_right;
    logic [SD_W-1:0]       mono_sum;
    logic [MIX_W-1:0]      left_val;
    logic [MIX_W-1:0]      right_val;

    assign tick = (div_cnt == DIV_LAST);
    assign busy = (state != IDLE);

    // Free-running frame divider, restarted by reset
    always_ff @(posedge clk32) begin
        if (rst || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk32) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: a frame starts only on an enabled tick and runs to COMMIT
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tick && en) next_state = LOAD;
            LOAD:    next_state = MUL;
            MUL:     if (bit_idx == STEP_LAST && ch_idx == 2'd3) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One shift-add step of the current channel, plus the output mix selection
    always_comb begin
        cur_dac = dac_snap[ch_idx];
        cur_vol = vol_snap[ch_idx];
        addend  = '0;
        if (cur_vol[bit_idx]) begin
            addend = PROD_W'(cur_dac) << bit_idx;
        end
        prod_next = prod + addend;
        mono_sum  = SD_W'(acc_left) + SD_W'(acc_right);
        if (MONO) begin
            left_val  = MIX_W'(mono_sum >> 1);
            right_val = MIX_W'(mono_sum >> 1);
        end else begin
            left_val  = acc_left;
            right_val = acc_right;
        end
    end

    // Datapath: snapshot, multiply-accumulate per channel, commit at frame end
    always_ff @(posedge clk32) begin
        if (rst) begin
            dac_snap   <= '0;
            vol_snap   <= '0;
            ch_idx     <= '0;
            bit_idx    <= '0;
            prod       <= '0;
            acc_left   <= '0;
            acc_right  <= '0;
            mix_left   <= '0;
            mix_right  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                LOAD: begin
                    dac_snap  <= {dac3, dac2, dac1, dac0};
                    vol_snap  <= {vol3, vol2, vol1, vol0};
                    ch_idx    <= '0;
                    bit_idx   <= '0;
                    prod      <= '0;
                    acc_left  <= '0;
                    acc_right <= '0;
                end
                MUL: begin
                    if (bit_idx == STEP_LAST) begin
                        bit_idx <= '0;
                        prod    <= '0;
                        ch_idx  <= ch_idx + 1'b1;
                        if (ch_idx[1]) begin
                            acc_right <= acc_right + MIX_W'(prod_next);
                        end else begin
                            acc_left <= acc_left + MIX_W'(prod_next);
                        end
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        prod    <= prod_next;
                    end
                end
                COMMIT: begin
                    mix_left   <= left_val;
                    mix_right  <= right_val;
                    frame_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    sd_modulator_1st u_sd_left (
        .clk (clk32),
        .rst (rst),
        .mix (mix_left),
        .sd  (sd_left)
    );

    sd_modulator_1st u_sd_right (
        .clk (clk32),
        .rst (rst),
        .mix (mix_right),
        .sd  (sd_right)
    );

endmodule

// File: tb/tb_gs_dac_mixer.sv
// tb_gs_dac_mixer: table-driven and random frames against a product-sum
// model, plus timing, reset, enable and sigma-delta sequences.
module tb_gs_dac_mixer;

    typedef struct {
        logic [3:0][7:0] dac;
        logic [3:0][5:0] vol;
        int              exp_l;
        int              exp_r;
        int              exp_m;
    } vec_t;

    localparam int NUM_FIXED = 6;
    localparam int NUM_RAND  = 16;
    localparam int NUM_VEC   = NUM_FIXED + NUM_RAND;

    logic        clk32 = 1'b0;
    logic        rst   = 1'b1;
    logic        en    = 1'b0;
    logic [7:0]  dac0 = '0, dac1 = '0, dac2 = '0, dac3 = '0;
    logic [5:0]  vol0 = '0, vol1 = '0, vol2 = '0, vol3 = '0;
    logic [14:0] mix_left, mix_right, m_mix_left, m_mix_right;
    logic        frame_done, busy, sd_left, sd_right;
    logic        m_frame_done, m_busy, m_sd_left, m_sd_right;

    int   cyc     = 0;
    int   rel_cyc = 0;
    int   checks  = 0;
    int   errors  = 0;
    vec_t vecs[NUM_VEC];

    gs_dac_mixer #(.SAMPLE_DIV(32), .MONO(1'b0)) dut (
        .clk32(clk32), .rst(rst), .en(en),
        .dac0(dac0), .dac1(dac1), .dac2(dac2), .dac3(dac3),
        .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
        .mix_left(mix_left), .mix_right(mix_right), .frame_done(frame_done),
        .busy(busy), .sd_left(sd_left), .sd_right(sd_right)
    );

    gs_dac_mixer #(.SAMPLE_DIV(32), .MONO(1'b1)) dut_mono (
        .clk32(clk32), .rst(rst), .en(en),
        .dac0(dac0), .dac1(dac1), .dac2(dac2), .dac3(dac3),
        .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
        .mix_left(m_mix_left), .mix_right(m_mix_right), .frame_done(m_frame_done),
        .busy(m_busy), .sd_left(m_sd_left), .sd_right(m_sd_right)
    );

    // 32 MHz-style clock
    always #5 clk32 = ~clk32;

    // Cycle counter used for latency checks
    always @(posedge clk32) cyc <= cyc + 1;

    // Safety net in case the stimulus sequence stalls
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int side_sum(input logic [3:0][7:0] d, input logic [3:0][5:0] v,
                                    input int first);
        return int'(d[first]) * int'(v[first]) + int'(d[first+1]) * int'(v[first+1]);
    endfunction

    function automatic vec_t make_vec(input logic [3:0][7:0] d, input logic [3:0][5:0] v);
        vec_t r;
        r.dac   = d;
        r.vol   = v;
        r.exp_l = side_sum(d, v, 0);
        r.exp_r = side_sum(d, v, 2);
        r.exp_m = (r.exp_l + r.exp_r) / 2;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0][7:0] d, input logic [3:0][5:0] v);
        dac0 = d[0]; dac1 = d[1]; dac2 = d[2]; dac3 = d[3];
        vol0 = v[0]; vol1 = v[1]; vol2 = v[2]; vol3 = v[3];
    endtask

    task automatic step();
        @(posedge clk32);
        #1;
    endtask

    // Waits for the next frame_done; reports first busy cycle seen on the way
    task automatic waitFrame(input int limit, output int done_cyc, output int busy_start);
        done_cyc   = -1;
        busy_start = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (busy && busy_start < 0) busy_start = cyc;
            if (frame_done) begin
                done_cyc = cyc;
                break;
            end
        end
        checkOutput("frame_done_seen", int'(done_cyc >= 0), 1);
    endtask

    task automatic doReset(input string tag);
        rst = 1'b1;
        step();
        checkOutput({tag, "_mix_left"},   int'(mix_left),   0);
        checkOutput({tag, "_mix_right"},  int'(mix_right),  0);
        checkOutput({tag, "_frame_done"}, int'(frame_done), 0);
        checkOutput({tag, "_busy"},       int'(busy),       0);
        checkOutput({tag, "_sd_left"},    int'(sd_left),    0);
        rst     = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic checkFrame(input string tag, input vec_t v, input int done_cyc,
                              input int busy_start);
        checkOutput({tag, "_left"},       int'(mix_left),    v.exp_l);
        checkOutput({tag, "_right"},      int'(mix_right),   v.exp_r);
        checkOutput({tag, "_mono_left"},  int'(m_mix_left),  v.exp_m);
        checkOutput({tag, "_mono_right"}, int'(m_mix_right), v.exp_m);
        checkOutput({tag, "_phase"},      (done_cyc - rel_cyc) % 32, 26);
        checkOutput({tag, "_busy_start"}, busy_start, done_cyc - 26);
    endtask

    initial begin
        int   done_c, busy_c, ones_l, ones_r, bad, resid, s, n_done, n_busy;
        vec_t v;
        logic [3:0][7:0] d;
        logic [3:0][5:0] w;

        vecs[0] = make_vec({8'h00, 8'h00, 8'h00, 8'hFF}, {6'd0, 6'd0, 6'd0, 6'd63});
        vecs[1] = make_vec({8'hFF, 8'hFF, 8'hFF, 8'hFF}, {6'd63, 6'd63, 6'd63, 6'd63});
        vecs[2] = make_vec({8'h80, 8'h80, 8'h80, 8'h80}, {6'd63, 6'd63, 6'd63, 6'd63});
        vecs[3] = make_vec({8'hFF, 8'hFF, 8'hFF, 8'hFF}, {6'd0, 6'd0, 6'd0, 6'd0});
        vecs[4] = make_vec({8'h00, 8'h00, 8'h00, 8'h00}, {6'd63, 6'd63, 6'd63, 6'd63});
        vecs[5] = make_vec({8'h01, 8'h02, 8'hFF, 8'h80}, {6'd63, 6'd1, 6'd33, 6'd21});
        for (int i = NUM_FIXED; i < NUM_VEC; i++) begin
            for (int k = 0; k < 4; k++) begin
                d[k] = 8'($urandom_range(0, 255));
                w[k] = 6'($urandom_range(0, 63));
            end
            vecs[i] = make_vec(d, w);
        end
        checkOutput("model_single_ch", vecs[0].exp_l, 16065);
        checkOutput("model_mono", vecs[2].exp_m, 16128);

        repeat (3) step();
        doReset("reset");

        // First frame after reset: latency and exact sigma-delta pattern
        applyStimulus({8'h00, 8'h00, 8'h00, 8'h80}, {6'd0, 6'd0, 6'd0, 6'd32});
        en = 1'b1;
        waitFrame(100, done_c, busy_c);
        checkOutput("first_done_latency", done_c - rel_cyc, 58);
        checkOutput("first_busy_start", busy_c - rel_cyc, 32);
        checkOutput("half_scale_left", int'(mix_left), 4096);
        checkOutput("half_scale_right", int'(mix_right), 0);
        checkOutput("first_sd_left", int'(sd_left), 0);
        resid = 0; bad = 0; ones_l = 0; ones_r = 0;
        for (int j = 0; j < 64; j++) begin
            step();
            s     = resid + 4096;
            resid = s % 32768;
            if (int'(sd_left) != int'(s >= 32768)) bad++;
            ones_l += int'(sd_left);
            ones_r += int'(sd_right);
        end
        checkOutput("sd_left_pattern_errs", bad, 0);
        checkOutput("sd_left_ones_64", ones_l, 8);
        checkOutput("sd_right_ones_64", ones_r, 0);

        // Table of fixed and random vectors
        waitFrame(80, done_c, busy_c);
        for (int i = 0; i < NUM_VEC; i++) begin
            applyStimulus(vecs[i].dac, vecs[i].vol);
            waitFrame(80, done_c, busy_c);
            checkFrame($sformatf("vec%0d", i), vecs[i], done_c, busy_c);
        end

        // Input change after the snapshot only affects the next frame
        v = make_vec({8'h00, 8'h00, 8'h00, 8'h10}, {6'd0, 6'd0, 6'd0, 6'd20});
        applyStimulus(v.dac, v.vol);
        waitFrame(80, done_c, busy_c);
        checkOutput("pre_change_left", int'(mix_left), 320);
        repeat (10) step();
        checkOutput("busy_at_tick_plus5", int'(busy), 1);
        dac0 = 8'hF0;
        waitFrame(80, done_c, busy_c);
        checkOutput("snapshot_held_left", int'(mix_left), 320);
        waitFrame(80, done_c, busy_c);
        checkOutput("next_frame_left", int'(mix_left), 4800);

        // Near full-scale density over one full residue period
        applyStimulus({8'hFF, 8'hFF, 8'hFF, 8'hFF}, {6'd63, 6'd63, 6'd63, 6'd63});
        waitFrame(80, done_c, busy_c);
        checkOutput("full_left", int'(mix_left), 32130);
        checkOutput("full_right", int'(mix_right), 32130);
        ones_l = 0; ones_r = 0;
        for (int j = 0; j < 32768; j++) begin
            step();
            ones_l += int'(sd_left);
            ones_r += int'(sd_right);
        end
        checks++;
        if (ones_l < 32129 || ones_l > 32131) begin
            errors++;
            $display("[TB] FAIL sd_left_density: got %0d, expected 32130 +/-1", ones_l);
        end
        checks++;
        if (ones_r < 32129 || ones_r > 32131) begin
            errors++;
            $display("[TB] FAIL sd_right_density: got %0d, expected 32130 +/-1", ones_r);
        end

        // Reset in the middle of a frame abandons it
        waitFrame(80, done_c, busy_c);
        v = make_vec({8'h00, 8'h00, 8'h00, 8'h40}, {6'd0, 6'd0, 6'd0, 6'd10});
        applyStimulus(v.dac, v.vol);
        repeat (15) step();
        checkOutput("busy_before_rst", int'(busy), 1);
        doReset("midframe_rst");
        n_done = 0;
        done_c = -1;
        for (int j = 0; j < 100; j++) begin
            step();
            if (frame_done) begin
                n_done++;
                done_c = cyc;
                break;
            end
        end
        checkOutput("post_rst_done_count", n_done, 1);
        checkOutput("post_rst_done_latency", done_c - rel_cyc, 58);
        checkOutput("post_rst_left", int'(mix_left), 640);

        // Disabled frames: no busy, no frame_done, outputs hold
        en = 1'b0;
        applyStimulus({8'hFF, 8'hFF, 8'hFF, 8'hFF}, {6'd63, 6'd63, 6'd63, 6'd63});
        n_done = 0; n_busy = 0;
        for (int j = 0; j < 70; j++) begin
            step();
            n_done += int'(frame_done);
            n_busy += int'(busy);
        end
        checkOutput("en0_frame_done", n_done, 0);
        checkOutput("en0_busy", n_busy, 0);
        checkOutput("en0_hold_left", int'(mix_left), 640);
        checkOutput("en0_hold_right", int'(mix_right), 0);
        en = 1'b1;
        waitFrame(80, done_c, busy_c);
        checkOutput("reenable_left", int'(mix_left), 32130);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
